// File: rtl/multi_ch_handshake_sender.sv
// Multi-channel 4-phase req/ack source controller: queues single-cycle events per channel
// and runs one full handshake per queued event, flagging handshakes that stall.
module multi_ch_handshake_sender #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset_in,
  input  logic [NUM_CH-1:0]         vld_in,
  output logic [NUM_CH-1:0]         rdy_out,
  output logic [NUM_CH-1:0]         req_out,
  input  logic [NUM_CH-1:0]         ack_in,
  output logic [NUM_CH-1:0]         done_out,
  output logic [NUM_CH*CNT_W-1:0]   pend_cnt_out,
  output logic [NUM_CH-1:0]         timeout_out,
  input  logic [NUM_CH-1:0]         clear_timeout_in
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TW-1:0]    T_MAX   = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO} state_t;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] pending;
    logic [TW-1:0]    timer;
    logic             req_q;
    logic             done_q;
    logic             timeout_q;
    logic             accept;
    logic             launch;
    logic             timeout_set;

    assign accept      = vld_in[g] && (pending != CNT_MAX);
    // A stale ack (e.g. left high across a reset) must fall before a new request goes out.
    assign launch      = (state == IDLE) && (pending != '0) && !ack_in[g];
    assign timeout_set = (state != IDLE) && (timer == T_MAX - 1'b1);

    assign rdy_out[g]                      = (pending != CNT_MAX);
    assign req_out[g]                      = req_q;
    assign done_out[g]                     = done_q;
    assign timeout_out[g]                  = timeout_q;
    assign pend_cnt_out[g*CNT_W +: CNT_W]  = pending;

    // NOTE: all state updates use non-blocking assignments so every channel register
    // samples the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
      if (reset_in) begin
        state     <= IDLE;
        pending   <= '0;
        timer     <= '0;
        req_q     <= 1'b0;
        done_q    <= 1'b0;
        timeout_q <= 1'b0;
      end else begin
        done_q <= 1'b0;

        case (state)
          IDLE: begin
            if (launch) begin
              state <= REQ_HI;
              req_q <= 1'b1;
              timer <= '0;
            end
          end
          REQ_HI: begin
            if (ack_in[g]) begin
              state <= REQ_LO;
              req_q <= 1'b0;
            end
          end
          REQ_LO: begin
            if (!ack_in[g]) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase

        // The handshake is never aborted; the timer only saturates and reports.
        if (state != IDLE && timer != T_MAX) timer <= timer + 1'b1;

        if (accept && !launch)      pending <= pending + 1'b1;
        else if (!accept && launch) pending <= pending - 1'b1;

        if (timeout_set)               timeout_q <= 1'b1;
        else if (clear_timeout_in[g])  timeout_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multi_ch_handshake_sender.sv
// Directed bench for multi_ch_handshake_sender: a vector table for short sequences plus
// hand-written sequences for multi-channel timing, saturation and timeout behaviour.
module tb_multi_ch_handshake_sender;

  logic        clk = 1'b0;
  logic        reset_in;
  logic [3:0]  vld_in, ack_in, clear_timeout_in;
  logic [3:0]  rdy_out, req_out, done_out, timeout_out;
  logic [11:0] pend_cnt_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_ch_handshake_sender #(.NUM_CH(4), .CNT_W(3), .TIMEOUT(64)) dut (
    .clk              (clk),
    .reset_in         (reset_in),
    .vld_in           (vld_in),
    .rdy_out          (rdy_out),
    .req_out          (req_out),
    .ack_in           (ack_in),
    .done_out         (done_out),
    .pend_cnt_out     (pend_cnt_out),
    .timeout_out      (timeout_out),
    .clear_timeout_in (clear_timeout_in)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  vld, ack, clr;
    logic [3:0]  req, done, rdy;
    logic [11:0] pend;
    logic [3:0]  to;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [11:0] pk(input int c0, input int c1, input int c2, input int c3);
    return {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
  endfunction

  task automatic add(input logic rst, input logic [3:0] vld, input logic [3:0] ack,
                     input logic [3:0] req, input logic [3:0] done, input logic [11:0] pend);
    vec_t v;
    v.rst = rst; v.vld = vld; v.ack = ack; v.clr = 4'b0000;
    v.req = req; v.done = done; v.rdy = 4'b1111; v.pend = pend; v.to = 4'b0000;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply inputs, let one rising edge pass, then sample on the falling edge.
  task automatic cycle(input logic rst, input logic [3:0] vld, input logic [3:0] ack,
                       input logic [3:0] clr);
    reset_in = rst; vld_in = vld; ack_in = ack; clear_timeout_in = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset_in = 1'b1; vld_in = '0; ack_in = '0; clear_timeout_in = '0;

    // ch0 single event (ack follows req after two cycles), ch2 launch+accept overlap,
    // ch3 reset mid-handshake with a stale ack.
    add(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, pk(1,0,0,0));
    add(0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, pk(0,0,0,0));
    add(0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, pk(0,0,0,0));
    add(0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, pk(0,0,0,0));
    add(0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, pk(0,0,0,0));
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0001, pk(0,0,0,0));
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, pk(0,0,0,0));
    add(0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, pk(0,0,1,0));
    add(0, 4'b0100, 4'b0000, 4'b0100, 4'b0000, pk(0,0,1,0));
    add(0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, pk(0,0,1,0));
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, pk(0,0,1,0));
    add(0, 4'b0000, 4'b0000, 4'b0100, 4'b0000, pk(0,0,0,0));
    add(0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, pk(0,0,0,0));
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, pk(0,0,0,0));
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, pk(0,0,0,0));
    add(0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, pk(0,0,0,1));
    add(0, 4'b0000, 4'b0000, 4'b1000, 4'b0000, pk(0,0,0,0));
    add(1, 4'b0000, 4'b1000, 4'b0000, 4'b0000, pk(0,0,0,0));
    add(0, 4'b1000, 4'b1000, 4'b0000, 4'b0000, pk(0,0,0,1));
    add(0, 4'b0000, 4'b1000, 4'b0000, 4'b0000, pk(0,0,0,1));
    add(0, 4'b0000, 4'b0000, 4'b1000, 4'b0000, pk(0,0,0,0));
    add(0, 4'b0000, 4'b1000, 4'b0000, 4'b0000, pk(0,0,0,0));
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b1000, pk(0,0,0,0));

    // Reset state
    cycle(1, '0, '0, '0);
    cycle(1, '0, '0, '0);
    check("reset_req",  32'(req_out),      32'h0);
    check("reset_done", 32'(done_out),     32'h0);
    check("reset_to",   32'(timeout_out),  32'h0);
    check("reset_rdy",  32'(rdy_out),      32'hF);
    check("reset_pend", 32'(pend_cnt_out), 32'h0);

    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].vld, vecs[i].ack, vecs[i].clr);
      check($sformatf("vec%0d_req",  i), 32'(req_out),      32'(vecs[i].req));
      check($sformatf("vec%0d_done", i), 32'(done_out),     32'(vecs[i].done));
      check($sformatf("vec%0d_rdy",  i), 32'(rdy_out),      32'(vecs[i].rdy));
      check($sformatf("vec%0d_pend", i), 32'(pend_cnt_out), 32'(vecs[i].pend));
      check($sformatf("vec%0d_to",   i), 32'(timeout_out),  32'(vecs[i].to));
    end

    // All channels fire together; ack follows req with delay d = 1,3,5,7.
    // req rises after edge 2, ack high for edges 2+d..2+2d-1, done after edge 2+2d.
    for (int e = 1; e <= 18; e++) begin
      logic [3:0] ack_v, exp_req, exp_done;
      for (int c = 0; c < 4; c++) begin
        int d;
        d = 2 * c + 1;
        ack_v[c]    = (e >= 2 + d) && (e < 2 + 2 * d);
        exp_req[c]  = (e >= 2) && (e < 2 + d);
        exp_done[c] = (e == 2 + 2 * d);
      end
      cycle(0, (e == 1) ? 4'b1111 : 4'b0000, ack_v, '0);
      check($sformatf("multi_e%0d_req", e),  32'(req_out),  32'(exp_req));
      check($sformatf("multi_e%0d_done", e), 32'(done_out), 32'(exp_done));
    end
    check("multi_pend_idle", 32'(pend_cnt_out), 32'h0);

    // ch1: vld held 10 cycles, ack never returns -> saturate at 7, timeout 64 cycles after req rise.
    for (int k = 1; k <= 66; k++) begin
      int exp_p;
      cycle(0, (k <= 10) ? 4'b0010 : 4'b0000, '0, '0);
      exp_p = (k == 1) ? 1 : ((k - 1 > 7) ? 7 : k - 1);
      if (k <= 10) begin
        check($sformatf("sat_k%0d_pend", k), 32'(pend_cnt_out[5:3]), 32'(exp_p));
        check($sformatf("sat_k%0d_rdy", k),  32'(rdy_out[1]),        32'(exp_p != 7));
      end
      if (k == 65) check("ch1_to_before", 32'(timeout_out[1]), 32'h0);
      if (k == 66) begin
        check("ch1_to_set",     32'(timeout_out[1]), 32'h1);
        check("ch1_req_held",   32'(req_out[1]),     32'h1);
        check("ch1_pend_sat",   32'(pend_cnt_out[5:3]), 32'h7);
      end
    end
    cycle(0, '0, '0, 4'b0010);
    check("ch1_to_clear", 32'(timeout_out[1]), 32'h0);

    // ch0: clear pulsed in the very cycle the flag sets -> set wins; a later clear wins.
    for (int k = 1; k <= 66; k++) begin
      cycle(0, (k == 1) ? 4'b0001 : 4'b0000, '0, (k == 66) ? 4'b0001 : 4'b0000);
      if (k == 65) check("ch0_to_before", 32'(timeout_out[0]), 32'h0);
    end
    check("ch0_set_wins", 32'(timeout_out[0]), 32'h1);
    cycle(0, '0, '0, '0);
    check("ch0_to_sticky", 32'(timeout_out[0]), 32'h1);
    cycle(0, '0, '0, 4'b0001);
    check("ch0_to_clear", 32'(timeout_out[0]), 32'h0);
    check("ch1_to_stays_clear", 32'(timeout_out[1]), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
